// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's two write ports: three result sources,
// round-robin order, up to two writes per cycle, all register-file controls registered.
module regfile_wb_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_stall,
  input  logic [2:0]      src_valid,
  input  logic [2:0]      src_dual,
  input  logic [3*AW-1:0] src_reg1,
  input  logic [3*DW-1:0] src_data1,
  input  logic [3*AW-1:0] src_reg2,
  input  logic [3*DW-1:0] src_data2,
  output logic [2:0]      src_ready,
  output logic            RegWrite,
  output logic            WriteOP2,
  output logic [AW-1:0]   WriteReg1,
  output logic [AW-1:0]   WriteReg2,
  output logic [DW-1:0]   WriteData1,
  output logic [DW-1:0]   WriteData2,
  output logic [2:0]      last_grant
);

  logic [1:0]    r_ptr;
  logic          r_regwrite;
  logic          r_op2;
  logic [AW-1:0] r_wreg1;
  logic [AW-1:0] r_wreg2;
  logic [DW-1:0] r_wdata1;
  logic [DW-1:0] r_wdata2;
  logic [2:0]    r_last;

  logic [AW-1:0] w_r1 [3];
  logic [AW-1:0] w_r2 [3];
  logic [DW-1:0] w_d1 [3];
  logic [DW-1:0] w_d2 [3];
  logic [1:0]    w_ord [3];
  logic          w_found;
  logic [1:0]    w_fpos;
  logic [1:0]    w_first;
  logic [1:0]    w_second;
  logic          w_pack;
  logic [2:0]    w_grant;
  logic [1:0]    w_ptr_d;

  function automatic logic [1:0] f_inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_r1[i] = src_reg1[i*AW +: AW];
      w_r2[i] = src_reg2[i*AW +: AW];
      w_d1[i] = src_data1[i*DW +: DW];
      w_d2[i] = src_data2[i*DW +: DW];
    end
  end

  always_comb begin
    w_ord[0] = r_ptr;
    w_ord[1] = f_inc3(r_ptr);
    w_ord[2] = f_inc3(w_ord[1]);
  end

  always_comb begin
    w_found  = 1'b0;
    w_fpos   = 2'd0;
    w_second = 2'd0;
    w_pack   = 1'b0;
    w_grant  = 3'b000;
    w_ptr_d  = r_ptr;
    for (int k = 0; k < 3; k++) begin
      if (!w_found && src_valid[w_ord[k]]) begin
        w_found = 1'b1;
        w_fpos  = 2'(k);
      end
    end
    w_first = w_ord[w_fpos];
    // Only the immediately next source may pack; skipping a dual would starve it.
    if (w_fpos != 2'd2) begin
      w_second = w_ord[w_fpos + 2'd1];
      w_pack   = !src_dual[w_first] && src_valid[w_second] && !src_dual[w_second] &&
                 (w_r1[w_second] != w_r1[w_first]);
    end
    if (w_found && !wb_stall && !rst) begin
      w_grant[w_first] = 1'b1;
      if (w_pack) begin
        w_grant[w_second] = 1'b1;
        w_ptr_d           = f_inc3(w_second);
      end else begin
        w_ptr_d = f_inc3(w_first);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= 2'd0;
      r_regwrite <= 1'b0;
      r_op2      <= 1'b0;
      r_wreg1    <= '0;
      r_wreg2    <= '0;
      r_wdata1   <= '0;
      r_wdata2   <= '0;
      r_last     <= 3'b000;
    end else begin
      r_ptr  <= w_ptr_d;
      r_last <= w_grant;
      if (|w_grant) begin
        r_regwrite <= 1'b1;
        r_wreg1    <= w_r1[w_first];
        if (src_dual[w_first]) begin
          // A dual to one register collapses to a single write of the later value.
          if (w_r1[w_first] == w_r2[w_first]) begin
            r_wdata1 <= w_d2[w_first];
            r_op2    <= 1'b0;
          end else begin
            r_wdata1 <= w_d1[w_first];
            r_wreg2  <= w_r2[w_first];
            r_wdata2 <= w_d2[w_first];
            r_op2    <= 1'b1;
          end
        end else begin
          r_wdata1 <= w_d1[w_first];
          if (w_pack) begin
            r_wreg2  <= w_r1[w_second];
            r_wdata2 <= w_d1[w_second];
            r_op2    <= 1'b1;
          end else begin
            r_op2 <= 1'b0;
          end
        end
      end else begin
        r_regwrite <= 1'b0;
        r_op2      <= 1'b0;
      end
    end
  end

  assign src_ready  = w_grant;
  assign RegWrite   = r_regwrite;
  assign WriteOP2   = r_op2;
  assign WriteReg1  = r_wreg1;
  assign WriteReg2  = r_wreg2;
  assign WriteData1 = r_wdata1;
  assign WriteData2 = r_wdata2;
  assign last_grant = r_last;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scheduler for the 16-entry register file's dual write ports. Three result sources compete each cycle for the two ports: 0 = ALU pipe, 1 = load unit, 2 = multiply/divide unit. The block picks up to two writes per cycle in round-robin order and drives the register file's RegWrite, WriteOP2, WriteReg1/2 and WriteData1/2 from registered outputs. It sits between the pipeline's write-back stage and the register file.

## Interface
- DW, 16, data width of each write
- AW, 4, register address width
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- wb_stall  input  1  when high, no source is granted this cycle
- src_valid  input  3  per-source request valid
- src_dual  input  3  per-source flag: request carries two writes
- src_reg1  input  3*AW  per-source first destination; source i occupies bits [i*AW +: AW]
- src_data1  input  3*DW  per-source first data
- src_reg2  input  3*AW  per-source second destination, used only when dual
- src_data2  input  3*DW  per-source second data, used only when dual
- src_ready  output  3  combinational grant per source; a transfer occurs on valid & ready
- RegWrite  output  1  registered; register file write enable, port 1
- WriteOP2  output  1  registered; port 2 enable, only meaningful with RegWrite
- WriteReg1, WriteReg2  output  AW each  registered destinations
- WriteData1, WriteData2  output  DW each  registered data
- last_grant  output  3  registered one-hot-or-two-hot record of the sources granted in the previous cycle

## Operation
- State: 2-bit round-robin pointer ptr (values 0..2) plus the output registers.
- Search order each cycle: ptr, ptr+1, ptr+2 (mod 3).
- first = first source in search order with valid = 1.
- If wb_stall = 1 or no source is valid: src_ready = 0, and the next-cycle RegWrite = 0.
- If first is dual: grant first only.
  - Port 1 = reg1/data1; port 2 = reg2/data2; WriteOP2 = 1.
  - Exception: if reg1 == reg2, issue a single write of data2 to reg1 with WriteOP2 = 0.
- If first is single: second = the immediately next source in search order.
  - Pack second onto port 2 only if it is valid, single, and its reg1 ≠ first's reg1.
  - Otherwise grant first alone with WriteOP2 = 0.
  - The next-in-order rule is deliberate. Skipping a pending dual request is forbidden, which keeps the scheme starvation-free.
- Pointer update on any grant: ptr ← (index of last granted source in search order) + 1, mod 3. With no grant, ptr holds.
- Fairness guarantee: a source that keeps valid asserted is granted within 3 non-stalled cycles.
- Output registers load the selected fields on a grant. On a non-grant cycle, RegWrite = 0 and WriteOP2 = 0; the address and data registers hold their values.
- Port 2 addresses never equal port 1 addresses when WriteOP2 = 1. The register file's port-2-wins collision rule is therefore never exercised.

## Timing
- Reset (rst = 1 at a clk edge) sets:
  - ptr = 0
  - RegWrite = 0, WriteOP2 = 0
  - WriteReg1 = WriteReg2 = 0, WriteData1 = WriteData2 = 0
  - last_grant = 0
- During reset, src_ready = 0.
- Reset asserted mid-operation discards the grant decision of that cycle. No write is issued on the following cycle.
- src_ready is combinational from src_valid, src_dual, src_reg*, ptr, wb_stall and rst.
- Sources must not derive src_valid from src_ready.
- A source holds valid and its fields stable until accepted.
- Latency:
  - accept at edge N → RegWrite/WriteOP2 high during cycle N+1
  - register file updated at edge N+1
  - value readable through ReadData from cycle N+1 onward, after that edge
- Throughput: up to 2 register writes per cycle; at most one dual request per cycle.
- wb_stall takes effect in the same cycle. Outputs already registered still write in that cycle.

## Test plan
- Reset with all three sources valid and single → src_ready = 000 while rst = 1. After release, RegWrite = 0, ptr = 0, and the first grant is src_ready = 011.
- Single-source sweep: src0 single reg1 = 3, data1 = 16'hABCD, ptr = 0 → src_ready = 001. Next cycle: RegWrite = 1, WriteOP2 = 0, WriteReg1 = 3, WriteData1 = 16'hABCD. ptr becomes 1.
- Packing and conflict:
  - src1 (reg 5, 16'h1111) and src2 (reg 6, 16'h2222), ptr = 1 → grant 110, port 1 = 5/16'h1111, port 2 = 6/16'h2222, ptr becomes 0.
  - Repeat with both targeting reg 5 → grant 010 only, then 100 on the next cycle.
- Dual: src2 dual (reg1 = 8, 16'hFF56; reg2 = 9, 16'h0001), ptr = 2 → grant 100, WriteOP2 = 1, ptr becomes 0. With reg1 = reg2 = 8 → WriteOP2 = 0, WriteData1 = 16'h0001.
- Fairness: src0 and src2 hold single requests continuously and src1 holds a dual. Over 6 cycles src1 is granted at least twice, and it is never skipped while src2 is packed.
- Stall: wb_stall = 1 for 3 cycles with all sources valid → src_ready = 000, RegWrite = 0 and ptr unchanged. The cycle after release grants from the unchanged ptr.
